// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider and the ALU decoder.
package div_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam logic [3:0]  ALUCTRL_DIV = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH+1:0] shifted;
    logic             fits;

    // Trial subtraction; keep the difference only when it is non-negative.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        fits    = (shifted >= (WIDTH+2)'(divisor_i));
        rem_o   = fits ? (WIDTH+1)'(shifted - (WIDTH+2)'(divisor_i)) : shifted[WIDTH:0];
        quo_o   = {quo_i[WIDTH-2:0], fits};
    end

endmodule : div_step

// File: rtl/div_sequencer.sv
// Multi-cycle DIV controller: stalls the pipeline, runs a restoring divide, owns HI/LO.
module div_sequencer
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [3:0]       alucontrol,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned      CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic             signed_q, signed_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             dbz_q, dbz_d;

    logic             start;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (b_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Issue detection; flush wins over a same-cycle start.
    assign start = valid && (alucontrol == ALUCTRL_DIV) && (state_q == S_IDLE) && !flush;
    assign stall = busy_q | start;
    assign busy  = busy_q;
    assign done  = done_q;
    assign div_by_zero = dbz_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            signed_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            signed_q <= signed_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            dbz_q    <= dbz_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        signed_d = signed_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;

        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_PREP;
                        a_d      = dividend;
                        b_d      = divisor;
                        signed_d = is_signed;
                        qneg_d   = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_d   = is_signed & dividend[WIDTH-1];
                    end
                end
                S_PREP: begin
                    quo_d   = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
                    b_d     = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
                    rem_d   = '0;
                    count_d = '0;
                    state_d = S_ITER;
                end
                S_ITER: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = S_FIX;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    // A zero divisor reports all-ones quotient and the untouched dividend.
                    if (b_q == '0) begin
                        lo_d  = '1;
                        hi_d  = a_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d  = qneg_q ? -quo_q : quo_q;
                        hi_d  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                        dbz_d = 1'b0;
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

endmodule : div_sequencer

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed divides, flush, reset and zero-divisor cases.
module tb_div_sequencer;
    import div_pkg::*;

    localparam int W       = 32;
    localparam int LATENCY = W + 3;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         valid;
    logic [3:0]   alucontrol;
    logic         is_signed;
    logic         flush;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         stall;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    div_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid       (valid),
        .alucontrol  (alucontrol),
        .is_signed   (is_signed),
        .flush       (flush),
        .dividend    (dividend),
        .divisor     (divisor),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            exp_t e;
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("lo", lo, e.lo);
                chk("hi", hi, e.hi);
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Drive one DIV for a single cycle; optionally register its expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic push, input logic [W-1:0] e_lo, input logic [W-1:0] e_hi,
                         input logic e_dbz, output int c);
        exp_t e;
        @(negedge clk);
        valid      = 1'b1;
        alucontrol = ALUCTRL_DIV;
        is_signed  = sgn;
        dividend   = a;
        divisor    = b;
        c          = cyc;
        if (push) begin
            e.lo  = e_lo;
            e.hi  = e_hi;
            e.dbz = e_dbz;
            e.cyc = c + LATENCY;
            exp_q.push_back(e);
        end
        #1 chk("stall_issue", 32'(stall), 32'd1);
        @(negedge clk);
        valid      = 1'b0;
        alucontrol = 4'd0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input logic [W-1:0] e_lo, input logic [W-1:0] e_hi, input logic e_dbz);
        int c;
        issue(a, b, sgn, 1'b1, e_lo, e_hi, e_dbz, c);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int d0;
        reset_n    = 1'b0;
        valid      = 1'b0;
        alucontrol = 4'd0;
        is_signed  = 1'b0;
        flush      = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_dbz",   32'(div_by_zero), 32'd0);
        chk("rst_hi",    hi, 32'd0);
        chk("rst_lo",    lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 100 / 7 with the stall window traced cycle by cycle
        issue(32'd100, 32'd7, 1'b1, 1'b1, 32'd14, 32'd2, 1'b0, c);
        for (int k = 1; k <= LATENCY; k++) begin
            wait_to(c + k);
            #1 chk("stall_window", 32'(stall), 32'd1);
        end
        wait_to(c + LATENCY + 1);
        #1;
        chk("stall_after_done", 32'(stall), 32'd0);
        chk("busy_after_done",  32'(busy),  32'd0);
        wait_idle();

        run(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);
        run(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);

        // Second start ignored while busy, then flushed mid-iteration
        d0 = n_done;
        issue(32'd100, 32'd7, 1'b1, 1'b0, '0, '0, 1'b0, c);
        wait_to(c + 10);
        valid      = 1'b1;
        alucontrol = ALUCTRL_DIV;
        dividend   = 32'd1;
        divisor    = 32'd1;
        #1 chk("busy_second_start", 32'(busy), 32'd1);
        @(negedge clk);
        valid      = 1'b0;
        alucontrol = 4'd0;
        wait_to(c + 20);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy",  32'(busy),  32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_lo",    lo, 32'h8000_0000);
        chk("flush_hi",    hi, 32'd0);
        chk("flush_dbz",   32'(div_by_zero), 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_no_done", 32'(n_done), 32'(d0));

        run(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0);

        // Reset asserted mid-operation
        d0 = n_done;
        issue(32'd100, 32'd7, 1'b1, 1'b0, '0, '0, 1'b0, c);
        wait_to(c + 15);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy",  32'(busy),  32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_done",  32'(done),  32'd0);
        chk("midrst_dbz",   32'(div_by_zero), 32'd0);
        chk("midrst_hi",    hi, 32'd0);
        chk("midrst_lo",    lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_no_done", 32'(n_done), 32'(d0));

        run(32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_sequencer

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for the MIPS DIV operation. It watches the decoded ALU control word and, on DIV, captures the operands and runs a signed restoring division over WIDTH iterations. It stalls the pipeline while busy and writes quotient/remainder into the HI/LO registers it owns. It sits beside the single-cycle ALU in the execute stage; the ALU never performs DIV itself.

## Interface
- WIDTH, 32: operand, quotient and remainder width.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid  in  1  execute stage holds a live instruction this cycle.
- alucontrol  in  4  decoded ALU control; DIV = 4'b1010.
- is_signed  in  1  1 = signed DIV, 0 = unsigned (reserved for DIVU).
- flush  in  1  synchronous cancel of an in-flight division.
- dividend  in  WIDTH  rs value.
- divisor  in  WIDTH  rt value.
- stall  out  1  hold the earlier pipeline stages.
- busy  out  1  division in progress.
- done  out  1  one-cycle pulse when hi/lo are updated.
- div_by_zero  out  1  registered; set with done when divisor was 0.
- hi  out  WIDTH  remainder register.
- lo  out  WIDTH  quotient register.

## Operation
- start = valid & (alucontrol == DIV) & state==IDLE; start in any other state is ignored.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE -> PREP on start: latch operands, is_signed, sign of quotient (sign(a)^sign(b)) and sign of remainder (sign(a)).
- PREP -> ITER: replace operands by magnitudes (signed mode), clear partial remainder, count=0.
- ITER: one restoring step per cycle (shift remainder left with next dividend MSB, subtract divisor, keep if non-negative, shift quotient bit in). After count==WIDTH-1 -> FIX.
- FIX: negate quotient/remainder per latched signs; write lo/hi; -> DONE.
- DONE: done=1 for this cycle; -> IDLE.
- Divisor 0: still walks all states; final lo = all ones, hi = original dividend, div_by_zero=1.
- Signed overflow (most negative / -1): lo = most negative value, hi = 0 (natural wrap, no flag).
- flush in any non-IDLE state -> IDLE next edge; hi, lo, div_by_zero unchanged; no done. flush has priority over start.
- Arithmetic: partial remainder WIDTH+1 bits; all negation is two's complement modulo 2^WIDTH.

## Timing
- Reset: state IDLE, hi=0, lo=0, done=0, busy=0, stall=0, div_by_zero=0, count=0.
- busy = (state != IDLE), registered state decode.
- stall = busy | start (combinational), so the issuing cycle is held too; stall drops in the cycle after DONE.
- Latency: start in cycle 0 -> PREP cycle 1 -> ITER cycles 2..WIDTH+1 -> FIX cycle WIDTH+2 -> done in cycle WIDTH+3 (35 for WIDTH=32).
- hi/lo and div_by_zero are valid in the done cycle and hold until the next completion.
- A new start is accepted at the earliest in the cycle after DONE.
- Reset asserted mid-operation: immediate return to reset values, no done.

## Structure
- Shared package div_pkg: state enum, ALUCTRL_DIV = 4'b1010 constant, also used by alu_decoder.
- Sub-module div_step: combinational single restoring step (remainder, quotient, divisor in; next remainder, next quotient out), instantiated once in ITER.

## Test plan
- 100 / 7 signed -> done at cycle 35, lo=14, hi=2, div_by_zero=0, stall high cycles 0..35.
- -7 / 2 signed -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); unsigned 0xFFFFFFF9 / 2 -> lo=0x7FFFFFFC, hi=1.
- 5 / 0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 at done; a following 9/3 clears it (lo=3, hi=0).
- 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0, no flag.
- A second start at cycle 10 with different operands is ignored; flush at cycle 20 -> IDLE at cycle 21, hi/lo keep their previous values, no done.
- reset_n low at cycle 15 -> all outputs zero immediately; a new DIV after release completes normally.
